// File: rtl/apb_uart_pkg.sv
// Shared constants and types for the APB UART transmit master.
// Register indices, LSR bit positions, init values and FSM state/phase encodings.
package apb_uart_pkg;

  localparam logic [2:0] REG_THR = 3'd0;
  localparam logic [2:0] REG_DLL = 3'd0;
  localparam logic [2:0] REG_DLM = 3'd1;
  localparam logic [2:0] REG_FCR = 3'd2;
  localparam logic [2:0] REG_LCR = 3'd3;
  localparam logic [2:0] REG_LSR = 3'd5;

  localparam int LSR_THRE = 5;
  localparam int LSR_TEMT = 6;

  localparam logic [7:0] LCR_DLAB = 8'h80;
  localparam logic [7:0] FCR_INIT = 8'h07;
  localparam logic [7:0] CHAR_LF  = 8'h0A;
  localparam logic [7:0] CHAR_CR  = 8'h0D;

  typedef enum logic [2:0] {
    ST_INIT_DLAB,
    ST_INIT_DLL,
    ST_INIT_DLM,
    ST_INIT_LCR,
    ST_INIT_FCR,
    ST_IDLE,
    ST_POLL_LSR,
    ST_SEND_THR
  } tx_state_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_ACCESS
  } apb_phase_e;

  // UART registers sit on 32-bit word boundaries.
  function automatic logic [31:0] reg_offset(input logic [2:0] idx);
    return {27'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/uart_tx_byte_fifo.sv
// Synchronous byte FIFO with occupancy count; DEPTH must be a power of two >= 2.
// Head entry is presented combinationally so the master can write it without a read bubble.
module uart_tx_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic [7:0] data_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign full_o  = (r_count == FULL_CNT);
  assign empty_o = (r_count == '0);
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign data_o  = r_mem[r_rd_ptr];

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/apb_uart_tx_master.sv
// APB3 initiator that initialises a 16550 UART and streams buffered bytes to THR.
// Optional LF -> CR,LF expansion when APB_UART_TX_MASTER_CRLF_EN is defined.
module apb_uart_tx_master
  import apb_uart_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] UART_BASE  = 32'h0000_0000,
  parameter logic [15:0] DIVISOR    = 16'd27,
  parameter logic [7:0]  LCR_VAL    = 8'h03
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  char_i,
  input  logic        char_valid_i,
  output logic        char_ready_o,
  output logic        init_done_o,
  output logic        busy_o,
  output logic        err_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [31:0] paddr_o,
  output logic [31:0] pwdata_o,
  input  logic [31:0] prdata_i,
  input  logic        pready_i,
  input  logic        pslverr_i
);

  tx_state_e  r_state;
  tx_state_e  w_state_next;
  apb_phase_e r_phase;
  apb_phase_e w_phase_next;
  logic       r_init_done;
  logic       w_init_done_next;
  logic       r_err;

  logic       w_done;
  logic       w_active;
  logic       w_push;
  logic       w_pop;
  logic [7:0] w_fifo_head;
  logic       w_fifo_full;
  logic       w_fifo_empty;
  logic [7:0] w_thr_byte;
  logic [2:0] w_reg_idx;
  logic       w_wr;
  logic [7:0] w_wdata;
  logic       w_unused_prdata;

`ifdef APB_UART_TX_MASTER_CRLF_EN
  logic       r_cr_sent;
  logic       w_cr_sent_next;
  logic       w_need_cr;

  assign w_need_cr  = (w_fifo_head == CHAR_LF) & ~r_cr_sent;
  assign w_thr_byte = w_need_cr ? CHAR_CR : w_fifo_head;
`else
  assign w_thr_byte = w_fifo_head;
`endif

  assign w_unused_prdata = ^{prdata_i[31:6], prdata_i[4:0]};

  uart_tx_byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (w_push),
    .data_i (char_i),
    .pop_i  (w_pop),
    .data_o (w_fifo_head),
    .full_o (w_fifo_full),
    .empty_o(w_fifo_empty)
  );

  assign char_ready_o = r_init_done & ~w_fifo_full;
  assign w_push       = char_valid_i & char_ready_o;
  assign init_done_o  = r_init_done;
  assign err_o        = r_err;
  assign busy_o       = ~w_fifo_empty | psel_o;

  assign w_done   = (r_phase == PH_ACCESS) & pready_i;
  assign w_active = (r_phase != PH_IDLE);

  // Bus outputs are decoded from registered state and forced to zero between transfers.
  assign psel_o    = w_active;
  assign penable_o = (r_phase == PH_ACCESS);
  assign pwrite_o  = w_active & w_wr;
  assign paddr_o   = w_active ? (UART_BASE + reg_offset(w_reg_idx)) : 32'h0;
  assign pwdata_o  = w_active ? {24'h0, w_wdata} : 32'h0;

  always_comb begin
    w_reg_idx = REG_THR;
    w_wr      = 1'b0;
    w_wdata   = 8'h00;
    case (r_state)
      ST_INIT_DLAB: begin w_reg_idx = REG_LCR; w_wr = 1'b1; w_wdata = LCR_DLAB;      end
      ST_INIT_DLL:  begin w_reg_idx = REG_DLL; w_wr = 1'b1; w_wdata = DIVISOR[7:0];  end
      ST_INIT_DLM:  begin w_reg_idx = REG_DLM; w_wr = 1'b1; w_wdata = DIVISOR[15:8]; end
      ST_INIT_LCR:  begin w_reg_idx = REG_LCR; w_wr = 1'b1; w_wdata = LCR_VAL;       end
      ST_INIT_FCR:  begin w_reg_idx = REG_FCR; w_wr = 1'b1; w_wdata = FCR_INIT;      end
      ST_POLL_LSR:  begin w_reg_idx = REG_LSR; w_wr = 1'b0; w_wdata = 8'h00;         end
      ST_SEND_THR:  begin w_reg_idx = REG_THR; w_wr = 1'b1; w_wdata = w_thr_byte;    end
      default:      begin w_reg_idx = REG_THR; w_wr = 1'b0; w_wdata = 8'h00;         end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_INIT_DLAB;
      r_phase     <= PH_IDLE;
      r_init_done <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_phase     <= w_phase_next;
      r_init_done <= w_init_done_next;
      r_err       <= r_err | (w_done & pslverr_i);
    end
  end

`ifdef APB_UART_TX_MASTER_CRLF_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cr_sent <= 1'b0;
    end else begin
      r_cr_sent <= w_cr_sent_next;
    end
  end
`endif

  always_comb begin
    w_state_next     = r_state;
    w_phase_next     = r_phase;
    w_init_done_next = r_init_done;
    w_pop            = 1'b0;
`ifdef APB_UART_TX_MASTER_CRLF_EN
    w_cr_sent_next   = r_cr_sent;
`endif

    // A completed transfer always returns to PH_IDLE, giving the mandatory idle cycle.
    if (r_state != ST_IDLE) begin
      case (r_phase)
        PH_IDLE:   w_phase_next = PH_SETUP;
        PH_SETUP:  w_phase_next = PH_ACCESS;
        PH_ACCESS: w_phase_next = pready_i ? PH_IDLE : PH_ACCESS;
        default:   w_phase_next = PH_IDLE;
      endcase
    end

    case (r_state)
      ST_INIT_DLAB: if (w_done) w_state_next = ST_INIT_DLL;
      ST_INIT_DLL:  if (w_done) w_state_next = ST_INIT_DLM;
      ST_INIT_DLM:  if (w_done) w_state_next = ST_INIT_LCR;
      ST_INIT_LCR:  if (w_done) w_state_next = ST_INIT_FCR;
      ST_INIT_FCR: begin
        if (w_done) begin
          w_state_next     = ST_IDLE;
          w_init_done_next = 1'b1;
        end
      end
      ST_IDLE: begin
        if (!w_fifo_empty) w_state_next = ST_POLL_LSR;
      end
      ST_POLL_LSR: begin
        // A slave error on the LSR read is treated as "not ready".
        if (w_done && prdata_i[LSR_THRE] && !pslverr_i) w_state_next = ST_SEND_THR;
      end
      ST_SEND_THR: begin
        if (w_done) begin
`ifdef APB_UART_TX_MASTER_CRLF_EN
          if (w_need_cr) begin
            w_cr_sent_next = 1'b1;
            w_state_next   = ST_POLL_LSR;
          end else begin
            w_pop          = 1'b1;
            w_cr_sent_next = 1'b0;
            w_state_next   = ST_IDLE;
          end
`else
          w_pop        = 1'b1;
          w_state_next = ST_IDLE;
`endif
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_apb_uart_tx_master.sv
// Directed bench for apb_uart_tx_master with a behavioural APB UART slave.
// The slave logs every completed transfer; each test compares its slice of the log.
module tb_apb_uart_tx_master;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [7:0]  char_i = 8'h00;
  logic        char_valid_i = 1'b0;
  logic        char_ready_o;
  logic        init_done_o;
  logic        busy_o;
  logic        err_o;
  logic        psel_o;
  logic        penable_o;
  logic        pwrite_o;
  logic [31:0] paddr_o;
  logic [31:0] pwdata_o;
  logic [31:0] prdata_i = 32'h0;
  logic        pready_i = 1'b0;
  logic        pslverr_i = 1'b0;

  always #5 clk_i = ~clk_i;

  apb_uart_tx_master #(
    .FIFO_DEPTH(8),
    .UART_BASE (32'h0000_0000),
    .DIVISOR   (16'd27),
    .LCR_VAL   (8'h03)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .char_i      (char_i),
    .char_valid_i(char_valid_i),
    .char_ready_o(char_ready_o),
    .init_done_o (init_done_o),
    .busy_o      (busy_o),
    .err_o       (err_o),
    .psel_o      (psel_o),
    .penable_o   (penable_o),
    .pwrite_o    (pwrite_o),
    .paddr_o     (paddr_o),
    .pwdata_o    (pwdata_o),
    .prdata_i    (prdata_i),
    .pready_i    (pready_i),
    .pslverr_i   (pslverr_i)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    int          acc;
  } xfer_t;

  xfer_t log_q[$];

  // Slave configuration (written by tests only)
  int          wait_cfg = 0;
  int          lsr_zero_until = 0;
  bit          lsr_hold = 0;
  bit          err_en = 0;
  logic [31:0] err_addr = 32'h0;

  // Slave state (written by the slave only)
  int          lsr_reads = 0;
  int          proto_viol = 0;
  int          stab_viol = 0;
  int          wait_left = 0;
  int          acc_cnt = 0;
  logic        prev_psel = 1'b0;
  logic [31:0] s_addr = 32'h0;
  logic [31:0] s_wdata = 32'h0;
  logic        s_wr = 1'b0;

  always @(negedge clk_i) begin
    xfer_t x;
    pready_i  = 1'b0;
    pslverr_i = 1'b0;
    prdata_i  = 32'h0;
    if (psel_o && !penable_o) begin
      if (prev_psel) proto_viol++;
      wait_left = wait_cfg;
      acc_cnt   = 0;
      s_addr    = paddr_o;
      s_wr      = pwrite_o;
      s_wdata   = pwdata_o;
    end else if (psel_o && penable_o) begin
      acc_cnt++;
      if ({paddr_o, pwrite_o, pwdata_o} !== {s_addr, s_wr, s_wdata}) stab_viol++;
      if (wait_left > 0) begin
        wait_left--;
      end else begin
        pready_i = 1'b1;
        if (err_en && pwrite_o && paddr_o == err_addr) pslverr_i = 1'b1;
        if (!pwrite_o && paddr_o == 32'h14) begin
          if (!lsr_hold && lsr_reads >= lsr_zero_until) prdata_i = 32'h60;
          lsr_reads++;
        end
        x.addr  = paddr_o;
        x.wr    = pwrite_o;
        x.wdata = pwdata_o;
        x.acc   = acc_cnt;
        log_q.push_back(x);
      end
    end
    prev_psel = psel_o;
  end

  function automatic logic [64:0] mk(input logic [31:0] a, input logic w, input logic [7:0] d);
    return {a, w, 24'h0, d};
  endfunction

  function automatic logic [64:0] got_at(input int idx);
    if (idx < log_q.size()) return {log_q[idx].addr, log_q[idx].wr, log_q[idx].wdata};
    return '1;
  endfunction

  task automatic push_byte(input logic [7:0] b);
    bit done = 0;
    char_i       = b;
    char_valid_i = 1'b1;
    for (int n = 0; n < 400 && !done; n++) begin
      if (char_ready_o) done = 1;
      @(posedge clk_i); #1;
    end
    char_valid_i = 1'b0;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL push_accept byte=%02h got=not_accepted exp=accepted", b);
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done = 0;
    for (int n = 0; n < budget && !done; n++) begin
      @(posedge clk_i); #1;
      if (!busy_o) done = 1;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s_idle got=busy exp=idle", name);
    end
  endtask

  task automatic wait_init(input string name);
    bit done = 0;
    bit ready_seen = 0;
    for (int n = 0; n < 200 && !done; n++) begin
      if (char_ready_o) ready_seen = 1;
      @(posedge clk_i); #1;
      if (init_done_o) done = 1;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s_init_timeout got=0 exp=1", name);
    end
    total++;
    if (ready_seen !== 1'b0) begin
      bad++;
      $display("FAIL %s_ready_during_init got=%0b exp=0", name, ready_seen);
    end
  endtask

  task automatic check_init_log(input string name, input int base);
    logic [64:0] exp [5];
    exp[0] = mk(32'h0C, 1'b1, 8'h80);
    exp[1] = mk(32'h00, 1'b1, 8'h1B);
    exp[2] = mk(32'h04, 1'b1, 8'h00);
    exp[3] = mk(32'h0C, 1'b1, 8'h03);
    exp[4] = mk(32'h08, 1'b1, 8'h07);
    total++;
    if (log_q.size() - base !== 5) begin
      bad++;
      $display("FAIL %s_init_count got=%0d exp=5", name, log_q.size() - base);
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (got_at(base + i) !== exp[i]) begin
        bad++;
        $display("FAIL %s_init_xfer%0d got=%h exp=%h", name, i, got_at(base + i), exp[i]);
      end
    end
  endtask

  task automatic test_reset();
    int base;
    bit seen = 0;
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    total++;
    if ({psel_o, penable_o, pwrite_o} !== 3'b000) begin
      bad++;
      $display("FAIL reset_apb_ctrl got=%b exp=000", {psel_o, penable_o, pwrite_o});
    end
    total++;
    if ({paddr_o, pwdata_o} !== 64'h0) begin
      bad++;
      $display("FAIL reset_apb_data got=%h exp=0", {paddr_o, pwdata_o});
    end
    total++;
    if ({init_done_o, busy_o, err_o, char_ready_o} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_status got=%b exp=0000", {init_done_o, busy_o, err_o, char_ready_o});
    end
    // Release, then re-assert reset while the first transfer is on the bus.
    rst_ni = 1'b1;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(posedge clk_i); #1;
      if (psel_o) seen = 1;
    end
    rst_ni = 1'b0;
    #1;
    total++;
    if ({seen, psel_o, penable_o, paddr_o} !== {1'b1, 2'b00, 32'h0}) begin
      bad++;
      $display("FAIL reset_mid_xfer got=%b_%b%b_%h exp=1_00_0", seen, psel_o, penable_o, paddr_o);
    end
    @(posedge clk_i); #1;
    base   = log_q.size();
    rst_ni = 1'b1;
    wait_init("reset");
    check_init_log("reset", base);
    total++;
    if ({init_done_o, char_ready_o, err_o, busy_o} !== 4'b1100) begin
      bad++;
      $display("FAIL reset_post_init got=%b exp=1100", {init_done_o, char_ready_o, err_o, busy_o});
    end
    $display("test_reset: init sequence of %0d writes observed", log_q.size() - base);
  endtask

  task automatic test_hi();
    int base = log_q.size();
    logic [7:0]  msg [3];
    logic [64:0] exp_q[$];
    msg[0] = 8'h48;
    msg[1] = 8'h69;
    msg[2] = 8'h0A;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk(32'h14, 1'b0, 8'h00));
`ifdef APB_UART_TX_MASTER_CRLF_EN
      if (msg[i] == 8'h0A) begin
        exp_q.push_back(mk(32'h00, 1'b1, 8'h0D));
        exp_q.push_back(mk(32'h14, 1'b0, 8'h00));
      end
`endif
      exp_q.push_back(mk(32'h00, 1'b1, msg[i]));
    end
    for (int i = 0; i < 3; i++) push_byte(msg[i]);
    wait_idle("hi", 500);
    total++;
    if (log_q.size() - base !== exp_q.size()) begin
      bad++;
      $display("FAIL hi_count got=%0d exp=%0d", log_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (got_at(base + i) !== exp_q[i]) begin
        bad++;
        $display("FAIL hi_xfer%0d got=%h exp=%h", i, got_at(base + i), exp_q[i]);
      end
    end
    $display("test_hi: %0d transfers observed", log_q.size() - base);
  endtask

  task automatic test_lsr_poll();
    int base = log_q.size();
    lsr_zero_until = lsr_reads + 3;
    push_byte(8'h55);
    wait_idle("poll", 500);
    total++;
    if (log_q.size() - base !== 5) begin
      bad++;
      $display("FAIL poll_count got=%0d exp=5", log_q.size() - base);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (got_at(base + i) !== mk(32'h14, 1'b0, 8'h00)) begin
        bad++;
        $display("FAIL poll_read%0d got=%h exp=%h", i, got_at(base + i), mk(32'h14, 1'b0, 8'h00));
      end
    end
    total++;
    if (got_at(base + 4) !== mk(32'h00, 1'b1, 8'h55)) begin
      bad++;
      $display("FAIL poll_write got=%h exp=%h", got_at(base + 4), mk(32'h00, 1'b1, 8'h55));
    end
    $display("test_lsr_poll: %0d transfers observed", log_q.size() - base);
  endtask

  task automatic test_wait_states();
    int base = log_q.size();
    int sv0  = stab_viol;
    wait_cfg = 5;
    push_byte(8'h33);
    wait_idle("wait", 500);
    wait_cfg = 0;
    total++;
    if (log_q.size() - base !== 2) begin
      bad++;
      $display("FAIL wait_count got=%0d exp=2", log_q.size() - base);
    end
    total++;
    if (got_at(base + 1) !== mk(32'h00, 1'b1, 8'h33)) begin
      bad++;
      $display("FAIL wait_write got=%h exp=%h", got_at(base + 1), mk(32'h00, 1'b1, 8'h33));
    end
    total++;
    if (log_q.size() > base + 1 && log_q[base + 1].acc !== 6) begin
      bad++;
      $display("FAIL wait_access_cycles got=%0d exp=6", log_q[base + 1].acc);
    end
    total++;
    if (stab_viol - sv0 !== 0) begin
      bad++;
      $display("FAIL wait_stability got=%0d exp=0", stab_viol - sv0);
    end
    $display("test_wait_states: write held %0d access cycles",
             (log_q.size() > base + 1) ? log_q[base + 1].acc : -1);
  endtask

  task automatic test_full();
    int base = log_q.size();
    int nw = 0;
    bit ready_seen = 0;
    lsr_hold = 1;
    for (int i = 0; i < 8; i++) push_byte(8'h10 + 8'(i));
    total++;
    if (char_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL full_ready got=%b exp=0", char_ready_o);
    end
    char_i       = 8'h18;
    char_valid_i = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk_i); #1;
      if (char_ready_o) ready_seen = 1;
    end
    total++;
    if (ready_seen !== 1'b0) begin
      bad++;
      $display("FAIL full_hold_ready got=%b exp=0", ready_seen);
    end
    for (int i = base; i < log_q.size(); i++) if (log_q[i].wr) nw++;
    total++;
    if (nw !== 0) begin
      bad++;
      $display("FAIL full_no_write got=%0d exp=0", nw);
    end
    lsr_hold = 0;
    push_byte(8'h18);
    wait_idle("full", 2000);
    nw = 0;
    for (int i = base; i < log_q.size(); i++) begin
      if (log_q[i].wr) begin
        total++;
        if ({log_q[i].addr, log_q[i].wdata} !== {32'h0, 24'h0, 8'h10 + 8'(nw)}) begin
          bad++;
          $display("FAIL full_write%0d got=%h_%h exp=0_%h", nw, log_q[i].addr, log_q[i].wdata, 8'h10 + 8'(nw));
        end
        nw++;
      end
    end
    total++;
    if (nw !== 9) begin
      bad++;
      $display("FAIL full_write_count got=%0d exp=9", nw);
    end
    $display("test_full: %0d THR writes observed", nw);
  endtask

  task automatic test_slverr();
    int base;
    err_en   = 1;
    err_addr = 32'h04;
    rst_ni   = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    base   = log_q.size();
    rst_ni = 1'b1;
    wait_init("slverr");
    check_init_log("slverr", base);
    total++;
    if (err_o !== 1'b1) begin
      bad++;
      $display("FAIL slverr_err_set got=%b exp=1", err_o);
    end
    err_en = 0;
    base   = log_q.size();
    push_byte(8'h41);
    wait_idle("slverr", 500);
    total++;
    if (got_at(log_q.size() - 1) !== mk(32'h00, 1'b1, 8'h41) || log_q.size() - base !== 2) begin
      bad++;
      $display("FAIL slverr_later_send got=%h n=%0d exp=%h n=2", got_at(log_q.size() - 1),
               log_q.size() - base, mk(32'h00, 1'b1, 8'h41));
    end
    total++;
    if (err_o !== 1'b1) begin
      bad++;
      $display("FAIL slverr_sticky got=%b exp=1", err_o);
    end
    $display("test_slverr: err_o=%b after later send", err_o);
  endtask

`ifdef APB_UART_TX_MASTER_CRLF_EN
  task automatic test_crlf();
    int base = log_q.size();
    logic [64:0] exp [4];
    exp[0] = mk(32'h14, 1'b0, 8'h00);
    exp[1] = mk(32'h00, 1'b1, 8'h0D);
    exp[2] = mk(32'h14, 1'b0, 8'h00);
    exp[3] = mk(32'h00, 1'b1, 8'h0A);
    push_byte(8'h0A);
    wait_idle("crlf", 500);
    total++;
    if (log_q.size() - base !== 4) begin
      bad++;
      $display("FAIL crlf_count got=%0d exp=4", log_q.size() - base);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (got_at(base + i) !== exp[i]) begin
        bad++;
        $display("FAIL crlf_xfer%0d got=%h exp=%h", i, got_at(base + i), exp[i]);
      end
    end
    $display("test_crlf: %0d transfers observed", log_q.size() - base);
  endtask
`endif

  initial begin
    test_reset();
    test_hi();
    test_lsr_poll();
    test_wait_states();
    test_full();
`ifdef APB_UART_TX_MASTER_CRLF_EN
    test_crlf();
`endif
    test_slverr();
    total++;
    if (proto_viol !== 0) begin
      bad++;
      $display("FAIL protocol_idle_gap got=%0d exp=0", proto_viol);
    end
    total++;
    if (stab_viol !== 0) begin
      bad++;
      $display("FAIL protocol_stability got=%0d exp=0", stab_viol);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
